// File: rtl/ahb_switch_master.sv
// AHB-Lite master: turns one switch/button command into a SINGLE or fixed-length
// INCR/WRAP burst of byte transfers towards one of two 8-bit slaves.
module ahb_switch_master #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          cmd_start,
    input  logic          cmd_write,
    input  logic          cmd_tgt,
    input  logic [AW-1:0] cmd_addr,
    input  logic [2:0]    cmd_burst,
    input  logic [DW-1:0] cmd_wdata,
    input  logic          hreadyout_1,
    input  logic          hresp_1,
    input  logic [DW-1:0] hrdata_1,
    input  logic          hreadyout_2,
    input  logic          hresp_2,
    input  logic [DW-1:0] hrdata_2,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hburst,
    output logic [DW-1:0] hwdata,
    output logic          hsel_1,
    output logic          hsel_2,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata_last,
    output logic [4:0]    beat_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_NSEQ, S_SEQ, S_LAST, S_ERR, S_DONE} state_t;

    localparam logic [1:0]    TR_IDLE   = 2'b00;
    localparam logic [1:0]    TR_NONSEQ = 2'b10;
    localparam logic [1:0]    TR_SEQ    = 2'b11;
    localparam logic [AW-1:0] ADDR_ONE  = 1;

    state_t        state;
    logic [1:0]    htrans_reg;
    logic [4:0]    len_reg;
    logic [4:0]    idx_reg;
    logic [DW-1:0] wbase_reg;
    logic          dp_valid;
    logic          dp_tgt;
    logic          dp_write;

    function automatic logic [4:0] burst_len(input logic [2:0] b);
        case (b[2:1])
            2'b00:   burst_len = 5'd1;
            2'b01:   burst_len = 5'd4;
            2'b10:   burst_len = 5'd8;
            default: burst_len = 5'd16;
        endcase
    endfunction

    // Response signals come from whichever slave owns the current data phase.
    logic          hready;
    logic          hresp_dp;
    logic [DW-1:0] hrdata_dp;
    logic          err_first;

    assign hready    = !dp_valid || (dp_tgt ? hreadyout_2 : hreadyout_1);
    assign hresp_dp  = dp_valid && (dp_tgt ? hresp_2 : hresp_1);
    assign hrdata_dp = dp_tgt ? hrdata_2 : hrdata_1;
    assign err_first = hresp_dp && !hready;

    // The pending address is cancelled already in the first error cycle.
    assign htrans = err_first ? TR_IDLE : htrans_reg;

    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] next_addr;
    logic          is_wrap;

    assign wrap_mask = AW'(len_reg - 5'd1);
    assign addr_inc  = haddr + ADDR_ONE;
    assign is_wrap   = !hburst[0] && (hburst[2:1] != 2'b00);
    assign next_addr = is_wrap ? ((haddr & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= S_IDLE;
            htrans_reg <= TR_IDLE;
            haddr      <= '0;
            hwrite     <= 1'b0;
            hburst     <= 3'b000;
            hwdata     <= '0;
            hsel_1     <= 1'b0;
            hsel_2     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata_last <= '0;
            beat_cnt   <= 5'd0;
            len_reg    <= 5'd0;
            idx_reg    <= 5'd0;
            wbase_reg  <= '0;
            dp_valid   <= 1'b0;
            dp_tgt     <= 1'b0;
            dp_write   <= 1'b0;
        end else begin
            // Pipeline advance: address phase becomes data phase, data phase retires.
            if (hready) begin
                dp_valid <= htrans_reg[1];
                if (htrans_reg[1]) begin
                    dp_tgt   <= hsel_2;
                    dp_write <= hwrite;
                    hwdata   <= wbase_reg + DW'(idx_reg);
                end
                if (dp_valid && !hresp_dp) begin
                    beat_cnt <= beat_cnt + 5'd1;
                    if (!dp_write)
                        rdata_last <= hrdata_dp;
                end
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (cmd_start) begin
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        beat_cnt   <= 5'd0;
                        htrans_reg <= TR_NONSEQ;
                        haddr      <= cmd_addr;
                        hwrite     <= cmd_write;
                        hburst     <= cmd_burst;
                        hsel_1     <= !cmd_tgt;
                        hsel_2     <= cmd_tgt;
                        len_reg    <= burst_len(cmd_burst);
                        idx_reg    <= 5'd0;
                        wbase_reg  <= cmd_wdata;
                        state      <= S_NSEQ;
                    end
                end
                S_NSEQ, S_SEQ: begin
                    if (err_first) begin
                        htrans_reg <= TR_IDLE;
                        hsel_1     <= 1'b0;
                        hsel_2     <= 1'b0;
                        state      <= S_ERR;
                    end else if (hready) begin
                        if (idx_reg == len_reg - 5'd1) begin
                            htrans_reg <= TR_IDLE;
                            hsel_1     <= 1'b0;
                            hsel_2     <= 1'b0;
                            state      <= S_LAST;
                        end else begin
                            htrans_reg <= TR_SEQ;
                            haddr      <= next_addr;
                            idx_reg    <= idx_reg + 5'd1;
                            state      <= S_SEQ;
                        end
                    end
                end
                S_LAST: begin
                    if (err_first) begin
                        state <= S_ERR;
                    end else if (hready) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_ERR: begin
                    if (hready) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ahb_switch_master.md
Name: ahb_switch_master

Overview:
- AHB-Lite master that turns a switch/button command into bus transfers for the two 8-bit AHB slaves.
- Sits directly upstream of the slave pair: drives the shared address/control/write-data bus and the per-slave selects, and consumes hreadyout/hresp/hrdata.
- Supports SINGLE and fixed-length INCR/WRAP bursts of byte transfers, with wait states and a two-cycle ERROR response.
- Reports completion, error, and the last read byte to the board-display logic.

Parameters:
- AW, 10, address width.
- DW, 8, data width.

Ports:
- hclk  in  1  bus clock
- hresetn  in  1  reset, asynchronous, active-low
- cmd_start  in  1  one-cycle start pulse; sampled only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_tgt  in  1  0 = slave 1, 1 = slave 2
- cmd_addr  in  AW  start address
- cmd_burst  in  3  hburst encoding
- cmd_wdata  in  DW  write data for beat 0
- hreadyout_1, hresp_1  in  1  slave 1 response
- hrdata_1  in  DW  slave 1 read data
- hreadyout_2, hresp_2  in  1  slave 2 response
- hrdata_2  in  DW  slave 2 read data
- haddr  out  AW  address
- htrans  out  2  transfer type
- hwrite  out  1  direction
- hburst  out  3  burst type
- hwdata  out  DW  write data (data phase)
- hsel_1, hsel_2  out  1  slave selects (address phase)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error of last command; cleared on next accepted start
- rdata_last  out  DW  last read byte captured
- beat_cnt  out  5  beats completed in current/last command

Behaviour:
- Reset (async assert, sync release): htrans=IDLE(00); haddr, hwrite, hburst, hwdata, hsel_x, busy, done, err, rdata_last, beat_cnt all 0; state IDLE.
- Burst length by cmd_burst:
  - 000 SINGLE = 1; 001 INCR is treated as 1 beat, with hburst driven as 001.
  - 010/011 = 4; 100/101 = 8; 110/111 = 16.
- Byte transfers only, so address steps by 1.
- INCR bursts wrap at 2^AW. WRAP bursts wrap within an aligned block of length bytes: next = (a & ~(L-1)) | ((a+1) & (L-1)).
- Write data for beat n = cmd_wdata + n, mod 2^DW. All cmd_* are latched at start.
- hready (internal): hreadyout of the slave owning the current data phase; 1 when there is no data phase. Same mux for hresp and hrdata.
- Pipelining: address phase N overlaps data phase N-1. Address/control and hwdata update only on hclk edges where hready=1. hwdata is valid in the cycle after its address is accepted.
- FSM states:
  - IDLE: on cmd_start, latch the command, busy=1, err=0, beat_cnt=0, go to NSEQ.
  - NSEQ: drive htrans=NONSEQ, haddr, hsel of target. When hready: if length=1 go to LAST, else go to SEQ.
  - SEQ: htrans=SEQ with the next address. When hready, the beat is accepted; after the final beat's address is accepted, go to LAST.
  - LAST: htrans=IDLE, hsel=0; final data phase. On hready go to DONE.
  - ERR: entered when the data-phase slave returns hresp=1 with hready=0. During that cycle, drive htrans=IDLE for the next edge (cancel the pending address). Next cycle (hresp=1, hready=1) set err=1 and go to DONE; no further beats.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- beat_cnt increments at the end of each data phase with hready=1 and hresp=0.
- Reads: rdata_last captures the muxed hrdata on each completed read data phase.
- cmd_start while busy is ignored with no effect. cmd_start and done in the same cycle: start is ignored.
- Reset mid-burst: immediate return to reset values; no partial done pulse.

Test Plan:
- SINGLE write, tgt=0, addr 0x010, data 0x5A, slaves always ready:
  - NONSEQ with addr 0x010 and hsel_1=1.
  - Next cycle hwdata=0x5A, then htrans=IDLE.
  - done pulses 3 cycles after start; beat_cnt=1; err=0.
- INCR4 write, tgt=1, addr 0x3FE, data 0x10:
  - haddr 3FE, 3FF, 000, 001; htrans NONSEQ, SEQ, SEQ, SEQ; hsel_2=1.
  - hwdata 10, 11, 12, 13, each one cycle after its address.
- WRAP4 read, tgt=0, addr 0x00E, slave returning data = addr:
  - haddr 0E, 0F, 0C, 0D.
  - rdata_last=0x0D at done; beat_cnt=4.
- Wait states: hreadyout_1 low for 2 cycles on beat 1 of INCR4:
  - haddr, htrans and hwdata held stable during the stall; total duration extends by exactly 2 cycles.
- Error: slave 1 gives hresp=1 on beat 2 data phase of INCR8 (hready=0, then hready=1):
  - htrans=IDLE from the first error cycle; no address 3 issued.
  - err=1, beat_cnt=2, done pulse.
  - cmd_start during the burst is ignored.
- Reset asserted mid-burst of INCR16:
  - All outputs 0 and htrans=IDLE immediately, without waiting for a clock edge.
  - No done pulse; a new start after release works normally.
